// File: rtl/dpram_pkg.sv
// Shared types and constants for the arbitrated dual-port RAM.
// Read latency depends on the optional DPRAM_OUTREG_EN output stage.
package dpram_pkg;

  typedef enum logic {ARB_A_PRI, ARB_B_PRI} arb_state_t;

`ifdef DPRAM_OUTREG_EN
  localparam int DPRAM_RD_LAT = 2;
`else
  localparam int DPRAM_RD_LAT = 1;
`endif

endpackage

// File: rtl/dpram_arb_if.sv
// Two-port request/grant bus between the masters and the arbitrated RAM.
interface dpram_arb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic              a_gnt;
  logic [DATA_W-1:0] a_dout;
  logic              a_dvalid;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic              b_gnt;
  logic [DATA_W-1:0] b_dout;
  logic              b_dvalid;
  logic              b_busy;

  modport master (
    output a_req, a_we, a_addr, a_din,
    output b_req, b_we, b_addr, b_din,
    input  a_gnt, a_dout, a_dvalid,
    input  b_gnt, b_dout, b_dvalid, b_busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    input  b_req, b_we, b_addr, b_din,
    output a_gnt, a_dout, a_dvalid,
    output b_gnt, b_dout, b_dvalid, b_busy
  );

endinterface

// File: rtl/dpram_arbiter.sv
// Same-address conflict detection and grant generation with Port A priority,
// plus a starvation counter that hands one conflict to Port B after STARVE_MAX denials.
module dpram_arbiter
  import dpram_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              a_gnt,
  output logic              b_gnt
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             conflict;

  // Two reads of one address are harmless; only a write makes a collision.
  assign conflict = a_req & b_req & (a_addr == b_addr) & (a_we | b_we);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_A_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    a_gnt          = 1'b0;
    b_gnt          = 1'b0;
    state_nxt      = state;
    starve_cnt_nxt = '0;
    if (rst_n) begin
      if (conflict) begin
        a_gnt = (state == ARB_A_PRI);
        b_gnt = (state == ARB_B_PRI);
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end

      if (b_req && !b_gnt)
        starve_cnt_nxt = starve_cnt + CNT_W'(1);

      // B priority lasts until B has been served once or withdraws.
      case (state)
        ARB_A_PRI:
          if (b_req && !b_gnt && (starve_cnt == CNT_W'(STARVE_MAX - 1)))
            state_nxt = ARB_B_PRI;
        ARB_B_PRI:
          if (b_gnt || !b_req)
            state_nxt = ARB_A_PRI;
        default:
          state_nxt = ARB_A_PRI;
      endcase
    end
  end

endmodule

// File: rtl/dpram_arb.sv
// True dual-port RAM with per-port req/gnt handshake and starvation-safe arbitration.
// Define DPRAM_OUTREG_EN to add an output register per port (read latency 2).
module dpram_arb
  import dpram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input logic        clk,
  input logic        rst_n,
  dpram_arb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              a_gnt, b_gnt;
  logic [DATA_W-1:0] a_rd_q, b_rd_q;
  logic              a_rv_q, b_rv_q;

  dpram_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_req  (bus.a_req),
    .a_we   (bus.a_we),
    .a_addr (bus.a_addr),
    .b_req  (bus.b_req),
    .b_we   (bus.b_we),
    .b_addr (bus.b_addr),
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  assign bus.a_gnt  = a_gnt;
  assign bus.b_gnt  = b_gnt;
  assign bus.b_busy = bus.b_req & ~b_gnt;

  // The arbiter never grants two writes to one address, so the ports never collide.
  always_ff @(posedge clk) begin
    if (a_gnt && bus.a_we)
      mem[bus.a_addr] <= bus.a_din;
    if (b_gnt && bus.b_we)
      mem[bus.b_addr] <= bus.b_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
    end else begin
      a_rv_q <= a_gnt & ~bus.a_we;
      b_rv_q <= b_gnt & ~bus.b_we;
      if (a_gnt && !bus.a_we)
        a_rd_q <= mem[bus.a_addr];
      if (b_gnt && !bus.b_we)
        b_rd_q <= mem[bus.b_addr];
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [DATA_W-1:0] a_out_q, b_out_q;
  logic              a_ov_q, b_ov_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out_q <= '0;
      b_out_q <= '0;
      a_ov_q  <= 1'b0;
      b_ov_q  <= 1'b0;
    end else begin
      a_ov_q <= a_rv_q;
      b_ov_q <= b_rv_q;
      if (a_rv_q)
        a_out_q <= a_rd_q;
      if (b_rv_q)
        b_out_q <= b_rd_q;
    end
  end

  assign bus.a_dout   = a_out_q;
  assign bus.b_dout   = b_out_q;
  assign bus.a_dvalid = a_ov_q;
  assign bus.b_dvalid = b_ov_q;
`else
  assign bus.a_dout   = a_rd_q;
  assign bus.b_dout   = b_rd_q;
  assign bus.a_dvalid = a_rv_q;
  assign bus.b_dvalid = b_rv_q;
`endif

endmodule

// File: tb/tb_dpram_arb.sv
// Scoreboard bench for dpram_arb: directed cycles push expected read data,
// a negedge monitor pops and compares whenever a dvalid appears.
module tb_dpram_arb;
  import dpram_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   check_cnt = 0;
  int   pass_cnt = 0;
  exp_t qa[$];
  exp_t qb[$];

  dpram_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dpram_arb #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp)
      pass_cnt++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One bus cycle: drive, check grants at negedge, queue expected read data.
  task automatic applyStimulus(
    input logic ar, input logic aw, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
    input logic br, input logic bw, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
    input logic ea, input logic eb,
    input logic [DATA_W-1:0] ra, input logic [DATA_W-1:0] rb
  );
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_din = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_din = bd;
    @(negedge clk);
    checkOutput("a_gnt", bus.a_gnt, ea);
    checkOutput("b_gnt", bus.b_gnt, eb);
    checkOutput("b_busy", bus.b_busy, br & ~eb);
    if (ar && !aw && ea && rst_n) qa.push_back('{ra, cyc + DPRAM_RD_LAT});
    if (br && !bw && eb && rst_n) qb.push_back('{rb, cyc + DPRAM_RD_LAT});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.a_dvalid) begin
      if (qa.size() == 0) begin
        checkOutput("a_spurious_dvalid", qa.size(), 1);
      end else begin
        e = qa.pop_front();
        checkOutput("a_dout", bus.a_dout, e.data);
        checkOutput("a_latency", cyc, e.cyc);
      end
    end
    if (bus.b_dvalid) begin
      if (qb.size() == 0) begin
        checkOutput("b_spurious_dvalid", qb.size(), 1);
      end else begin
        e = qb.pop_front();
        checkOutput("b_dout", bus.b_dout, e.data);
        checkOutput("b_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_din = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_din = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] reset behaviour");
    applyStimulus(1, 1, 12, 8'h21, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 12, 0, 1, 0, 12, 0, 1, 1, 8'h21, 8'h21);
    idle();
    rst_n = 1'b0;
    applyStimulus(1, 1, 12, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 12, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_a_dout", bus.a_dout, 0);
    checkOutput("rst_b_dout", bus.b_dout, 0);
    checkOutput("rst_a_dvalid", bus.a_dvalid, 0);
    checkOutput("rst_b_dvalid", bus.b_dvalid, 0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 12, 0, 0, 0, 0, 0, 1, 0, 8'h21, 0);
    idle();

    $display("[TB] parallel writes and cross reads");
    applyStimulus(1, 1, 5, 8'h3C, 1, 1, 9, 8'hA5, 1, 1, 0, 0);
    applyStimulus(1, 0, 9, 0, 1, 0, 5, 0, 1, 1, 8'hA5, 8'h3C);
    idle();

    $display("[TB] same-address reads");
    applyStimulus(1, 1, 7, 8'h11, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 7, 0, 1, 0, 7, 0, 1, 1, 8'h11, 8'h11);
    idle();

    $display("[TB] write/read conflict");
    applyStimulus(1, 1, 3, 8'h55, 1, 0, 3, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 0, 8'h55);
    idle();

    $display("[TB] starvation escape");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 4, 8'h40 + 8'(i), 1, 1, 4, 8'h77, 1, 0, 0, 0);
    applyStimulus(1, 1, 4, 8'h44, 1, 1, 4, 8'h77, 0, 1, 0, 0);
    applyStimulus(1, 0, 4, 0, 1, 1, 4, 8'h66, 1, 0, 8'h77, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 4, 8'h66, 0, 1, 0, 0);
    applyStimulus(1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 8'h66, 0);
    idle();

    $display("[TB] reset with reads in flight");
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 9;
    @(negedge clk);
    checkOutput("inflight_a_gnt", bus.a_gnt, 1);
    checkOutput("inflight_b_gnt", bus.b_gnt, 1);
    if (DPRAM_RD_LAT == 1) begin
      qa.push_back('{8'h3C, cyc + 1});
      qb.push_back('{8'hA5, cyc + 1});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.a_req = 0; bus.b_req = 0;
    @(posedge clk);
    #1;
    checkOutput("midrst_a_dout", bus.a_dout, 0);
    checkOutput("midrst_b_dout", bus.b_dout, 0);
    checkOutput("midrst_a_dvalid", bus.a_dvalid, 0);
    checkOutput("midrst_b_dvalid", bus.b_dvalid, 0);
    @(posedge clk);
    #1;
    checkOutput("midrst2_a_dvalid", bus.a_dvalid, 0);
    checkOutput("midrst2_b_dvalid", bus.b_dvalid, 0);
    rst_n = 1'b1;
    repeat (3) idle();

    for (int i = 0; i < 10 && (qa.size() != 0 || qb.size() != 0); i++)
      @(posedge clk);
    checkOutput("drain_a", qa.size(), 0);
    checkOutput("drain_b", qb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
